// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: loads a pattern into a scan chain, captures once, unloads and compares the response
module scan_seq_ctrl #(
   parameter int CHAIN_LEN = 3,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic                 scan_out,
   output logic                 scan_en,
   output logic                 scan_in,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response,
   output logic                 fail
);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, CAPTURE = 3'd2, UNLOAD = 3'd3, DONE = 3'd4;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
   logic [2:0] state;
   logic [CNT_W-1:0] cnt;
   logic [CHAIN_LEN-1:0] pat_q, exp_q, rsp_sh, rsp_nx, pat_sel;
   assign rsp_nx = {rsp_sh[CHAIN_LEN-2:0], scan_out};
   // MSB first: bit LAST-cnt of the latched pattern goes out this cycle
   assign pat_sel = pat_q >> (LAST - cnt);
   assign scan_en = state == LOAD || state == UNLOAD;
   assign scan_in = state == LOAD && pat_sel[0];
   assign busy = state == LOAD || state == CAPTURE || state == UNLOAD;
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         pat_q <= '0;
         exp_q <= '0;
         rsp_sh <= '0;
         response <= '0;
         fail <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               cnt <= '0;
               pat_q <= pattern;
               exp_q <= expected;
            end
            LOAD: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= CAPTURE;
                  cnt <= '0;
               end
            end
            CAPTURE: begin
               state <= UNLOAD;
               cnt <= '0;
               rsp_sh <= '0;
            end
            UNLOAD: begin
               rsp_sh <= rsp_nx;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  cnt <= '0;
                  response <= rsp_nx;
                  fail <= rsp_nx != exp_q;
               end
            end
            DONE: state <= IDLE;
            default: begin
               state <= IDLE;
               cnt <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb_scan_seq_ctrl: scoreboarded bench with a behavioural scan chain around each controller instance
module tb_scan_seq_ctrl;
   logic clk = 0, rst = 1, start = 0;
   logic [2:0] pattern = 0, expected = 0, response, s3;
   logic scan_out, scan_en, scan_in, busy, done, fail;
   logic st2 = 0, so2, se2, si2, bz2, dn2, fl2;
   logic [1:0] pat2 = 0, exp2 = 0, rsp2, s2;
   logic st7 = 0, so7, se7, si7, bz7, dn7, fl7;
   logic [6:0] pat7 = 0, exp7 = 0, rsp7, s7;
   int checks = 0, errors = 0, cyc = 0;
   typedef struct {logic [2:0] rsp; logic fl; int at;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   scan_seq_ctrl #(.CHAIN_LEN(3), .CNT_W(4)) dut (.clk(clk), .rst(rst), .start(start), .pattern(pattern),
      .expected(expected), .scan_out(scan_out), .scan_en(scan_en), .scan_in(scan_in), .busy(busy),
      .done(done), .response(response), .fail(fail));
   scan_seq_ctrl #(.CHAIN_LEN(2), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .start(st2), .pattern(pat2),
      .expected(exp2), .scan_out(so2), .scan_en(se2), .scan_in(si2), .busy(bz2), .done(dn2),
      .response(rsp2), .fail(fl2));
   scan_seq_ctrl #(.CHAIN_LEN(7), .CNT_W(3)) u7 (.clk(clk), .rst(rst), .start(st7), .pattern(pat7),
      .expected(exp7), .scan_out(so7), .scan_en(se7), .scan_in(si7), .busy(bz7), .done(dn7),
      .response(rsp7), .fail(fl7));

   // chain model: shift on scan_en, invert every flop on the capture cycle
   assign scan_out = s3[2];
   assign so2 = s2[1];
   assign so7 = s7[6];
   always @(posedge clk) if (scan_en) s3 <= {s3[1:0], scan_in}; else if (busy) s3 <= ~s3;
   always @(posedge clk) if (se2) s2 <= {s2[0], si2}; else if (bz2) s2 <= ~s2;
   always @(posedge clk) if (se7) s7 <= {s7[5:0], si7}; else if (bz7) s7 <= ~s7;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   always @(negedge clk) if (done) begin
      exp_t e;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
         e = sb.pop_front();
         chk("response", response, e.rsp);
         chk("fail", fail, e.fl);
         chk("done_cycle", cyc, e.at);
      end
   end

   // returns at the negedge of cycle 1 of the accepted run
   task automatic accept(input logic [2:0] p, input logic [2:0] e, input logic [2:0] r, input logic f);
      @(negedge clk);
      start = 1;
      pattern = p;
      expected = e;
      @(negedge clk);
      start = 0;
      sb.push_back('{r, f, cyc + 7});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      chk("pending_runs", sb.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] se_tab, si_tab, bz_tab;
      int n;
      se_tab = 8'b1110_1110;
      si_tab = 8'b0000_1010;
      bz_tab = 8'b1111_1110;
      repeat (2) @(negedge clk);
      chk("rst_scan_en", scan_en, 0);
      chk("rst_scan_in", scan_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_response", response, 0);
      chk("rst_fail", fail, 0);
      rst = 0;

      accept(3'b101, 3'b010, 3'b010, 0);
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("t1_scan_en_c%0d", k), scan_en, se_tab[k]);
         chk($sformatf("t1_scan_in_c%0d", k), scan_in, si_tab[k]);
         chk($sformatf("t1_busy_c%0d", k), busy, bz_tab[k]);
         @(negedge clk);
      end
      wait_idle();

      accept(3'b101, 3'b011, 3'b010, 1);
      wait_idle();

      accept(3'b101, 3'b010, 3'b010, 0);
      repeat (2) @(negedge clk);
      start = 1; pattern = 3'b011; expected = 3'b011;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_idle();
      repeat (10) @(negedge clk);
      chk("t3_idle_busy", busy, 0);

      accept(3'b110, 3'b001, 3'b001, 0);
      repeat (4) @(negedge clk);
      rst = 1;
      sb.delete();
      @(negedge clk);
      chk("t4_scan_en", scan_en, 0);
      chk("t4_busy", busy, 0);
      chk("t4_response", response, 0);
      chk("t4_fail", fail, 0);
      rst = 0;
      accept(3'b011, 3'b100, 3'b100, 0);
      wait_idle();

      @(negedge clk);
      start = 1; pattern = 3'b110; expected = 3'b001;
      @(negedge clk);
      sb.push_back('{3'b001, 1'b0, cyc + 7});
      repeat (8) @(negedge clk);
      chk("t5_gap_busy", busy, 0);
      chk("t5_gap_scan_en", scan_en, 0);
      pattern = 3'b001; expected = 3'b110;
      sb.push_back('{3'b110, 1'b0, cyc + 8});
      @(negedge clk);
      start = 0;
      for (int k = 10; k < 13; k++) begin
         chk($sformatf("t5_load_c%0d", k), scan_en & busy, 1);
         @(negedge clk);
      end
      wait_idle();

      @(negedge clk);
      st2 = 1; pat2 = 2'b10; exp2 = 2'b01;
      @(negedge clk);
      st2 = 0;
      n = 1;
      while (!dn2 && n < 40) begin @(negedge clk); n++; end
      chk("l2_done_cycle", n, 6);
      chk("l2_response", rsp2, 2'b01);
      chk("l2_fail", fl2, 0);

      @(negedge clk);
      st7 = 1; pat7 = 7'b1011001; exp7 = 7'b0100111;
      @(negedge clk);
      st7 = 0;
      n = 1;
      while (!dn7 && n < 60) begin @(negedge clk); n++; end
      chk("l7_done_cycle", n, 16);
      chk("l7_response", rsp7, 7'b0100110);
      chk("l7_fail", fl7, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
